// File: rtl/isqrt_pkg.sv
// Shared types and helpers for the sequential integer square root.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Root / remainder port width for a given radicand width.
  function automatic int root_w(input int w);
    return w / 2 + 1;
  endfunction

  // Floor square root by linear search; simulation reference only.
  function automatic longint unsigned isqrt_ref(input longint unsigned x);
    longint unsigned r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

endpackage

// File: rtl/isqrt_seq_if.sv
// Operand / result handshake bundle for isqrt_seq.
interface isqrt_seq_if #(parameter int WIDTH = 8);
  import isqrt_pkg::*;
  localparam int RW = root_w(WIDTH);

  logic             enb_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] dt_i;
  logic             round_i;
  logic             busy_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [RW-1:0]    dt_o;
  logic [RW-1:0]    rem_o;

  modport master (
    output enb_i, in_valid_i, dt_i, round_i, out_ready_i,
    input  in_ready_o, busy_o, out_valid_o, dt_o, rem_o
  );

  modport slave (
    input  enb_i, in_valid_i, dt_i, round_i, out_ready_i,
    output in_ready_o, busy_o, out_valid_o, dt_o, rem_o
  );
endinterface

// File: rtl/isqrt_step.sv
// One restoring root iteration: consumes two radicand bits, yields one root bit.
module isqrt_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH/2+1:0] rem_i,
  input  logic [WIDTH/2-1:0] root_i,
  input  logic [1:0]         bits_i,
  output logic [WIDTH/2+1:0] rem_o,
  output logic [WIDTH/2-1:0] root_o
);
  localparam int HW   = WIDTH / 2;
  localparam int REMW = HW + 2;

  logic [REMW+1:0] rem_sh;
  logic [REMW+1:0] trial;
  logic            ge;

  // Shift in the next bit pair and try subtracting (root<<2)|1.
  always_comb begin
    rem_sh = {rem_i, bits_i};
    trial  = {2'b00, root_i, 2'b01};
    ge     = (rem_sh >= trial);
    rem_o  = REMW'(ge ? (rem_sh - trial) : rem_sh);
    root_o = HW'({root_i, ge});
  end
endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root, one root bit per enabled clock.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  isqrt_seq_if.slave  bus
);
  localparam int HW   = WIDTH / 2;
  localparam int RW   = root_w(WIDTH);
  localparam int REMW = HW + 2;
  localparam int CW   = (HW > 1) ? $clog2(HW) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rad_q, rad_d;
  logic [REMW-1:0]  rem_q, rem_d;
  logic [HW-1:0]    root_q, root_d;
  logic             rnd_q, rnd_d;

  logic [REMW-1:0]  step_rem;
  logic [HW-1:0]    step_root;
  logic             accept;
  logic             round_up;

  isqrt_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[WIDTH-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  assign accept = bus.enb_i && bus.in_valid_i && (state_q == IDLE);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a low enable freezes the FSM.
  always_comb begin
    state_d = state_q;
    if (bus.enb_i) begin
      case (state_q)
        IDLE:    if (bus.in_valid_i)  state_d = CALC;
        CALC:    if (cnt_q == '0)     state_d = DONE;
        DONE:    if (bus.out_ready_i) state_d = IDLE;
        default:                      state_d = IDLE;
      endcase
    end
  end

  // FSM outputs plus rounding of the floor root.
  always_comb begin
    bus.in_ready_o  = bus.enb_i && (state_q == IDLE);
    bus.busy_o      = (state_q == CALC);
    bus.out_valid_o = (state_q == DONE);
    round_up        = rnd_q && (rem_q > {2'b00, root_q});
    bus.dt_o        = {1'b0, root_q} + RW'(round_up);
    bus.rem_o       = rem_q[RW-1:0];
  end

  // Datapath next state: load on accept, iterate in CALC.
  always_comb begin
    cnt_d  = cnt_q;
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    rnd_d  = rnd_q;
    if (accept) begin
      rad_d  = bus.dt_i;
      rnd_d  = bus.round_i;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = CW'(HW - 1);
    end else if (bus.enb_i && state_q == CALC) begin
      rad_d  = rad_q << 2;
      rem_d  = step_rem;
      root_d = step_root;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      rnd_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      rnd_q  <= rnd_d;
    end
  end
endmodule

// File: tb/tb_isqrt_seq.sv
// Scoreboard bench for isqrt_seq at WIDTH 8 and 16.
module tb_isqrt_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  isqrt_seq_if #(.WIDTH(8))  b8();
  isqrt_seq_if #(.WIDTH(16)) b16();

  isqrt_seq #(.WIDTH(8))  u8  (.clk_i(clk), .rst_ni(rst_n), .bus(b8));
  isqrt_seq #(.WIDTH(16)) u16 (.clk_i(clk), .rst_ni(rst_n), .bus(b16));

  int checks = 0;
  int errors = 0;
  int q8_root[$], q8_rem[$], q16_root[$], q16_rem[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drivers are called at posedge+#1 and return at posedge+#1 after the accept edge.
  task automatic send8(input int x, input bit r, input int er, input int erem);
    int n = 0;
    while (!b8.in_ready_o && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("w8_ready_timeout", 0, 1);
    b8.dt_i = x[7:0];
    b8.round_i = r;
    b8.in_valid_i = 1'b1;
    q8_root.push_back(er);
    q8_rem.push_back(erem);
    @(posedge clk); #1;
    b8.in_valid_i = 1'b0;
  endtask

  task automatic send16(input int x, input bit r, input int er, input int erem);
    int n = 0;
    while (!b16.in_ready_o && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("w16_ready_timeout", 0, 1);
    b16.dt_i = x[15:0];
    b16.round_i = r;
    b16.in_valid_i = 1'b1;
    q16_root.push_back(er);
    q16_rem.push_back(erem);
    @(posedge clk); #1;
    b16.in_valid_i = 1'b0;
  endtask

  task automatic wait_valid8(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b8.out_valid_o && n < 50);
    if (!b8.out_valid_o) chk("w8_valid_timeout", 0, 1);
  endtask

  task automatic wait_valid16(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b16.out_valid_o && n < 50);
    if (!b16.out_valid_o) chk("w16_valid_timeout", 0, 1);
  endtask

  // Monitors: compare on every completing output handshake.
  always @(negedge clk) begin
    int er, erm;
    if (rst_n && b8.out_valid_o && b8.out_ready_i && b8.enb_i) begin
      if (q8_root.size() == 0) chk("w8_unexpected_out", 1, 0);
      else begin
        er = q8_root.pop_front();
        erm = q8_rem.pop_front();
        chk("w8_root", b8.dt_o, er);
        chk("w8_rem", b8.rem_o, erm);
      end
    end
  end

  always @(negedge clk) begin
    int er, erm;
    if (rst_n && b16.out_valid_o && b16.out_ready_i && b16.enb_i) begin
      if (q16_root.size() == 0) chk("w16_unexpected_out", 1, 0);
      else begin
        er = q16_root.pop_front();
        erm = q16_rem.pop_front();
        chk("w16_root", b16.dt_o, er);
        chk("w16_rem", b16.rem_o, erm);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    int n, m, r;
    b8.enb_i = 0;  b8.in_valid_i = 0;  b8.dt_i = '0;  b8.round_i = 0;  b8.out_ready_i = 1;
    b16.enb_i = 0; b16.in_valid_i = 0; b16.dt_i = '0; b16.round_i = 0; b16.out_ready_i = 1;
    repeat (2) @(posedge clk); #1;

    chk("rst_in_ready", b8.in_ready_o, 0);
    chk("rst_busy", b8.busy_o, 0);
    chk("rst_out_valid", b8.out_valid_o, 0);
    chk("rst_dt_o", b8.dt_o, 0);
    chk("rst_rem_o", b8.rem_o, 0);
    chk("rst_w16_valid", b16.out_valid_o, 0);

    rst_n = 1'b1;
    b8.enb_i = 1'b1;
    b16.enb_i = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", b8.in_ready_o, 1);

    // Latency at WIDTH 8
    send8(144, 0, 12, 0);
    chk("busy_after_accept", b8.busy_o, 1);
    wait_valid8(n);
    chk("lat_w8", n, 4);

    // Exhaustive floor sweep
    for (int x = 0; x < 256; x++) begin
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      send8(x, 0, r, x - r * r);
    end

    // Round-to-nearest vectors
    send8(210, 1, 14, 14);
    send8(211, 1, 15, 15);
    send8(255, 1, 16, 30);
    send8(0,   1, 0,  0);
    repeat (8) @(posedge clk); #1;

    // Backpressure
    b8.out_ready_i = 1'b0;
    send8(100, 0, 10, 0);
    wait_valid8(n);
    chk("lat_bp", n, 4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_root", b8.dt_o, 10);
      chk("bp_rem", b8.rem_o, 0);
      chk("bp_in_ready", b8.in_ready_o, 0);
      chk("bp_valid", b8.out_valid_o, 1);
      @(posedge clk); #1;
    end
    b8.out_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_valid", b8.out_valid_o, 0);
    chk("bp_idle_ready", b8.in_ready_o, 1);

    // Enable dropped for 3 cycles mid-CALC
    send8(200, 0, 14, 4);
    @(posedge clk); #1;
    b8.enb_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("enb_busy_hold", b8.busy_o, 1);
    chk("enb_in_ready", b8.in_ready_o, 0);
    b8.enb_i = 1'b1;
    wait_valid8(m);
    chk("lat_enb", 4 + m, 7);
    repeat (3) @(posedge clk); #1;

    // Reset mid-CALC
    send8(50, 0, 7, 1);
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_busy", b8.busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", b8.busy_o, 0);
    chk("mid_rst_valid", b8.out_valid_o, 0);
    chk("mid_rst_dt", b8.dt_o, 0);
    chk("mid_rst_rem", b8.rem_o, 0);
    q8_root.delete();
    q8_rem.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_ready", b8.in_ready_o, 1);
    send8(81, 0, 9, 0);
    wait_valid8(n);
    chk("lat_post_rst", n, 4);

    // WIDTH 16
    send16(65535, 0, 255, 510);
    wait_valid16(n);
    chk("lat_w16", n, 8);
    send16(65535, 1, 256, 510);
    send16(1, 0, 1, 0);
    send16(40000, 0, 200, 0);

    repeat (14) @(posedge clk); #1;
    chk("w8_drained", q8_root.size(), 0);
    chk("w16_drained", q16_root.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/isqrt_seq.md
# isqrt_seq

Parametrised, sequential integer square root with a valid/ready handshake on both sides. It computes one result bit per clock using restoring digit-by-digit iteration. It returns the floor root and the remainder, or the root rounded to nearest, selected per operation. It generalises the 8-bit `sqrt` block: any even width, backpressure on the output, a remainder output and a rounding mode. It sits in the datapath wherever a multi-cycle root is acceptable.

## Interface
- `WIDTH`, 8: radicand width; even, ≥ 2. Derived: `RW = WIDTH/2 + 1` (root/remainder width).
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `enb_i`  in  1  global enable; low freezes all state.
- `in_valid_i`  in  1  operand valid.
- `in_ready_o`  out  1  block can accept an operand.
- `dt_i`  in  WIDTH  radicand, unsigned.
- `round_i`  in  1  mode: 0 = floor, 1 = round-to-nearest; sampled with `dt_i`.
- `busy_o`  out  1  iteration in progress.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer takes the result.
- `dt_o`  out  RW  root.
- `rem_o`  out  RW  remainder `dt_i − floor_root²`, always floor-based.

## Operation
- FSM states are IDLE, CALC and DONE. Reset state is IDLE.
- IDLE: `in_ready_o = enb_i`. A transfer (`in_valid_i && in_ready_o`) latches `dt_i` and `round_i`, clears root and remainder, loads counter `WIDTH/2−1`, and moves to CALC.
- CALC, once per enabled edge:
  - `rem = (rem<<2) | top two radicand bits`; shift the radicand left by 2.
  - `trial = (root<<2)|1`.
  - If `rem ≥ trial`: `rem −= trial`, `root = (root<<1)|1`. Otherwise `root <<= 1`.
  - Internal rem width is `WIDTH/2+2`.
  - When the counter reaches 0, go to DONE; otherwise decrement.
- DONE: `out_valid_o = 1`.
  - `dt_o` = root, plus 1 when the latched round bit is set and `rem > root`.
  - `rem_o` = rem, which is ≤ 2·root and fits in RW bits.
  - When `out_ready_i && enb_i`, go to IDLE.
- `busy_o = (state == CALC)`.
- `enb_i` low: no state, counter or datapath update. `in_ready_o = 0`; outputs hold. DONE keeps `out_valid_o` high, but no handshake completes.
- Outputs in DONE stay stable until the handshake completes.
- Rounding may produce `2^(WIDTH/2)`, e.g. 255 → 16 at WIDTH = 8. This is why the root port is RW bits wide.

## Timing
- Reset values: `in_ready_o`, `busy_o`, `out_valid_o` = 0; `dt_o`, `rem_o` = 0. `in_ready_o` rises combinationally from IDLE when `enb_i = 1`.
- Latency: accept at edge k gives `out_valid_o` high after edge k + WIDTH/2 (4 cycles at WIDTH = 8), with `enb_i` held high. Each low cycle of `enb_i` adds one cycle.
- Throughput: one operation per WIDTH/2 + 2 cycles when the consumer is always ready. There is no accept while busy or in DONE.
- Reset asserted mid-CALC or mid-DONE: immediate return to IDLE and the result is discarded. The first accept is possible on the first edge after release.
- Inputs `dt_i` and `round_i` are don't-care outside the accept edge.

## Structure
- `isqrt_pkg` holds:
  - the state enum (`IDLE`, `CALC`, `DONE`);
  - the width helper function `root_w(WIDTH)`;
  - the reference function for benches.
- Sub-module `isqrt_step`: combinational single iteration. Inputs are rem, root and the two radicand bits; outputs are next rem and next root. It is parametrised by WIDTH.
- Top level holds the FSM, counter, operand registers and the rounding adder.

## Test plan
- WIDTH = 8, exhaustive 0..255, floor mode, consumer always ready → `dt_o = floor(√x)` and `rem_o = x − dt_o²`. Includes 0 → 0/0, 144 → 12/0, 255 → 15/30.
- Round mode, WIDTH = 8:
  - 210 → 14 (rem 14, not > 14);
  - 211 → 15;
  - 255 → 16;
  - 0 → 0.
- Backpressure: hold `out_ready_i = 0` for 5 cycles after `out_valid_o`. `dt_o`/`rem_o` must stay stable, `in_ready_o = 0` throughout, and IDLE is reached one edge after ready.
- Drop `enb_i` for 3 cycles mid-CALC with input 200 → `out_valid_o` arrives 4 + 3 cycles after accept, result 14/4.
- Assert `rst_ni` mid-CALC → outputs 0 immediately. Next operation 81 → 9/0 with normal latency.
- WIDTH = 16:
  - 65535 floor → 255/510, round → 256, latency 8;
  - 1 → 1/0.
